// File: rtl/armleocpu_decode.sv
// Decode stage: one-entry F2D->D2E register, redirect forwarding and serialization of system/fence.i/interrupt packets.
// Latency 1 cycle F2D->D2E; fetch is stalled (d2f_ready=0) while the held packet is not consumed or a serializing packet is outstanding.
`ifndef F2E_TYPE_WIDTH
`define F2E_TYPE_WIDTH 1
`endif
`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`endif

module armleocpu_decode #(
    parameter int RESET_VECTOR_UNUSED = 0,
    parameter bit SERIALIZE_SYSTEM    = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic                                 f2d_valid,
    input  logic [`F2E_TYPE_WIDTH-1:0]           f2d_type,
    input  logic [31:0]                          f2d_instr,
    input  logic [31:0]                          f2d_pc,

    output logic                                 d2f_ready,
    output logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0]  d2f_cmd,
    output logic [31:0]                          d2f_branchtarget,

    output logic                                 d2e_valid,
    output logic [`F2E_TYPE_WIDTH-1:0]           d2e_type,
    output logic [31:0]                          d2e_instr,
    output logic [31:0]                          d2e_pc,
    output logic                                 d2e_illegal,
    output logic                                 d2e_serialize,
    input  logic                                 e2d_ready,
    input  logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0]  e2d_cmd,
    input  logic [31:0]                          e2d_branchtarget,

    output logic                                 dbg_pipeline_busy
);

    localparam logic [`F2E_TYPE_WIDTH-1:0] TYPE_INTERRUPT_PENDING = `F2E_TYPE_WIDTH'(1);

    localparam logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] CMD_NONE         = `ARMLEOCPU_D2F_CMD_WIDTH'(0);
    localparam logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] CMD_START_BRANCH = `ARMLEOCPU_D2F_CMD_WIDTH'(1);
    localparam logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] CMD_FLUSH        = `ARMLEOCPU_D2F_CMD_WIDTH'(2);

    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [2:0] FUNCT3_FENCE_I  = 3'b001;

    typedef enum logic {
        RUN         = 1'b0,
        WAIT_SERIAL = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] serial_pc;

    logic redirect;
    logic can_accept;
    logic f2d_serialize;
    logic held_fence_i;
    logic held_interrupt;
    logic retire;

    assign redirect   = (e2d_cmd != CMD_NONE);
    assign can_accept = !d2e_valid || e2d_ready;
    assign retire     = d2e_valid && e2d_ready;

    assign f2d_serialize = (f2d_type == TYPE_INTERRUPT_PENDING) ||
                           (SERIALIZE_SYSTEM &&
                            ((f2d_instr[6:0] == OPCODE_SYSTEM) ||
                             ((f2d_instr[6:0] == OPCODE_MISC_MEM) && (f2d_instr[14:12] == FUNCT3_FENCE_I))));

    // In WAIT_SERIAL the held packet is always the serializing one, so classify it from the d2e registers.
    assign held_interrupt = (d2e_type == TYPE_INTERRUPT_PENDING);
    assign held_fence_i   = (d2e_instr[6:0] == OPCODE_MISC_MEM) && (d2e_instr[14:12] == FUNCT3_FENCE_I);

    assign dbg_pipeline_busy = d2e_valid || (state == WAIT_SERIAL);

    always_comb begin
        d2f_ready        = 1'b0;
        d2f_cmd          = CMD_NONE;
        d2f_branchtarget = 32'h0;
        if (rst) begin
            d2f_ready = 1'b0;
        end else if (redirect) begin
            d2f_ready        = 1'b1;
            d2f_cmd          = e2d_cmd;
            d2f_branchtarget = e2d_branchtarget;
        end else if (state == RUN) begin
            d2f_ready = can_accept;
        end else if (retire && !held_interrupt) begin
            d2f_ready = 1'b1;
            if (held_fence_i) begin
                d2f_cmd = CMD_FLUSH;
            end else begin
                d2f_cmd          = CMD_START_BRANCH;
                d2f_branchtarget = serial_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            serial_pc     <= 32'(RESET_VECTOR_UNUSED);
            d2e_valid     <= 1'b0;
            d2e_type      <= '0;
            d2e_instr     <= 32'h0;
            d2e_pc        <= 32'h0;
            d2e_illegal   <= 1'b0;
            d2e_serialize <= 1'b0;
        end else if (redirect) begin
            d2e_valid <= 1'b0;
            state     <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (f2d_valid && can_accept) begin
                        d2e_valid     <= 1'b1;
                        d2e_type      <= f2d_type;
                        d2e_instr     <= f2d_instr;
                        d2e_pc        <= f2d_pc;
                        d2e_illegal   <= (f2d_instr[1:0] != 2'b11);
                        d2e_serialize <= f2d_serialize;
                        if (f2d_serialize) begin
                            state     <= WAIT_SERIAL;
                            serial_pc <= f2d_pc;
                        end
                    end else if (e2d_ready) begin
                        d2e_valid <= 1'b0;
                    end
                end
                WAIT_SERIAL: begin
                    // An interrupt stays parked here until execute redirects.
                    if (retire) begin
                        d2e_valid <= 1'b0;
                        if (!held_interrupt)
                            state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_armleocpu_decode.sv
// Directed bench for armleocpu_decode: streaming, backpressure, serialization, redirect and async reset.
`ifndef F2E_TYPE_WIDTH
`define F2E_TYPE_WIDTH 1
`endif
`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`endif

module tb_armleocpu_decode;

    localparam logic [31:0] ADDI   = 32'h00100093;
    localparam logic [31:0] CSRRW  = 32'h34011073;
    localparam logic [31:0] ECALL  = 32'h00000073;
    localparam logic [31:0] FENCEI = 32'h0000100F;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic                                clk = 1'b0;
    logic                                rst;
    logic                                f2d_valid;
    logic [`F2E_TYPE_WIDTH-1:0]          f2d_type;
    logic [31:0]                         f2d_instr;
    logic [31:0]                         f2d_pc;
    logic                                d2f_ready;
    logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd;
    logic [31:0]                         d2f_branchtarget;
    logic                                d2e_valid;
    logic [`F2E_TYPE_WIDTH-1:0]          d2e_type;
    logic [31:0]                         d2e_instr;
    logic [31:0]                         d2e_pc;
    logic                                d2e_illegal;
    logic                                d2e_serialize;
    logic                                e2d_ready;
    logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] e2d_cmd;
    logic [31:0]                         e2d_branchtarget;
    logic                                dbg_pipeline_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    armleocpu_decode #(.RESET_VECTOR_UNUSED(0), .SERIALIZE_SYSTEM(1'b1)) dut (
        .clk(clk), .rst(rst),
        .f2d_valid(f2d_valid), .f2d_type(f2d_type), .f2d_instr(f2d_instr), .f2d_pc(f2d_pc),
        .d2f_ready(d2f_ready), .d2f_cmd(d2f_cmd), .d2f_branchtarget(d2f_branchtarget),
        .d2e_valid(d2e_valid), .d2e_type(d2e_type), .d2e_instr(d2e_instr), .d2e_pc(d2e_pc),
        .d2e_illegal(d2e_illegal), .d2e_serialize(d2e_serialize),
        .e2d_ready(e2d_ready), .e2d_cmd(e2d_cmd), .e2d_branchtarget(e2d_branchtarget),
        .dbg_pipeline_busy(dbg_pipeline_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [`F2E_TYPE_WIDTH-1:0] t,
                         input logic [31:0] ins, input logic [31:0] pc, input logic er);
        f2d_valid = v;
        f2d_type  = t;
        f2d_instr = ins;
        f2d_pc    = pc;
        e2d_ready = er;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        f2d_valid = 0; f2d_type = 0; f2d_instr = 0; f2d_pc = 0;
        e2d_ready = 0; e2d_cmd = 0; e2d_branchtarget = 0;
        #1;
        chk("rst_d2e_valid", d2e_valid, 0);
        chk("rst_d2f_ready", d2f_ready, 0);
        chk("rst_d2f_cmd", d2f_cmd, 0);
        chk("rst_busy", dbg_pipeline_busy, 0);
        chk("rst_d2e_pc", d2e_pc, 0);
        cyc(); cyc();
        rst = 1'b0;

        // Streaming
        offer(1, 0, ADDI, 32'h1000, 1);
        chk("s_ready0", d2f_ready, 1);
        chk("s_cmd0", d2f_cmd, 0);
        cyc();
        chk("s_valid0", d2e_valid, 1);
        chk("s_pc0", d2e_pc, 32'h1000);
        chk("s_illegal0", d2e_illegal, 0);
        chk("s_ser0", d2e_serialize, 0);
        offer(1, 0, ADDI, 32'h1004, 1);
        chk("s_ready1", d2f_ready, 1);
        chk("s_cmd1", d2f_cmd, 0);
        cyc();
        chk("s_pc1", d2e_pc, 32'h1004);
        offer(1, 0, ADDI, 32'h1008, 1);
        chk("s_ready2", d2f_ready, 1);
        cyc();
        chk("s_pc2", d2e_pc, 32'h1008);
        chk("s_valid2", d2e_valid, 1);
        offer(0, 0, ADDI, 32'h100C, 1);
        cyc();
        chk("s_drain", d2e_valid, 0);

        // Backpressure
        offer(1, 0, ADDI, 32'h2000, 0);
        cyc();
        chk("bp_pc", d2e_pc, 32'h2000);
        for (int i = 0; i < 3; i++) begin
            offer(1, 0, 32'h00000000, 32'h2004, 0);
            chk("bp_ready", d2f_ready, 0);
            cyc();
            chk("bp_hold_pc", d2e_pc, 32'h2000);
            chk("bp_hold_valid", d2e_valid, 1);
        end
        offer(1, 0, 32'h00000000, 32'h2004, 1);
        chk("bp_release_ready", d2f_ready, 1);
        cyc();
        chk("bp_next_pc", d2e_pc, 32'h2004);
        chk("bp_illegal", d2e_illegal, 1);
        offer(0, 0, ADDI, 32'h0, 1);
        cyc();

        // CSRRW serializes and restarts at pc+4
        offer(1, 0, CSRRW, 32'h3000, 0);
        chk("csr_accept", d2f_ready, 1);
        cyc();
        chk("csr_ser", d2e_serialize, 1);
        chk("csr_busy", dbg_pipeline_busy, 1);
        offer(1, 0, ADDI, 32'h3004, 0);
        chk("csr_block", d2f_ready, 0);
        cyc();
        chk("csr_hold_pc", d2e_pc, 32'h3000);
        offer(1, 0, ADDI, 32'h3004, 1);
        chk("csr_ret_cmd", d2f_cmd, 1);
        chk("csr_ret_tgt", d2f_branchtarget, 32'h3004);
        chk("csr_ret_ready", d2f_ready, 1);
        cyc();
        chk("csr_not_captured", d2e_valid, 0);
        chk("csr_run_busy", dbg_pipeline_busy, 0);
        chk("csr_run_ready", d2f_ready, 1);
        chk("csr_run_cmd", d2f_cmd, 0);
        cyc();
        chk("csr_after_pc", d2e_pc, 32'h3004);
        chk("csr_after_ser", d2e_serialize, 0);
        offer(0, 0, ADDI, 32'h0, 1);
        cyc();

        // FENCE.I flushes for exactly one cycle
        offer(1, 0, FENCEI, 32'h4000, 1);
        cyc();
        chk("fi_ser", d2e_serialize, 1);
        offer(1, 0, ADDI, 32'h4004, 1);
        chk("fi_cmd", d2f_cmd, 2);
        chk("fi_ready", d2f_ready, 1);
        cyc();
        chk("fi_not_captured", d2e_valid, 0);
        offer(0, 0, ADDI, 32'h4004, 1);
        chk("fi_cmd_once", d2f_cmd, 0);
        cyc();

        // Serialized restart wraps at the top of the address space
        offer(1, 0, ECALL, 32'hFFFFFFFC, 0);
        cyc();
        offer(0, 0, ADDI, 32'h0, 1);
        chk("wrap_cmd", d2f_cmd, 1);
        chk("wrap_tgt", d2f_branchtarget, 32'h0);
        cyc();

        // Redirect from execute
        offer(1, 0, ADDI, 32'h5000, 0);
        cyc();
        chk("rd_loaded", d2e_valid, 1);
        e2d_cmd = 1; e2d_branchtarget = 32'h8000;
        offer(1, 0, ADDI, 32'h5004, 0);
        chk("rd_cmd", d2f_cmd, 1);
        chk("rd_tgt", d2f_branchtarget, 32'h8000);
        chk("rd_ready", d2f_ready, 1);
        cyc();
        e2d_cmd = 0; e2d_branchtarget = 0;
        offer(0, 0, ADDI, 32'h0, 0);
        chk("rd_dropped", d2e_valid, 0);
        chk("rd_busy", dbg_pipeline_busy, 0);

        // Interrupt parks in WAIT_SERIAL until reset
        offer(1, 1, NOP, 32'h6000, 0);
        cyc();
        chk("irq_ser", d2e_serialize, 1);
        chk("irq_type", d2e_type, 1);
        offer(1, 0, ADDI, 32'h6004, 1);
        chk("irq_ret_ready", d2f_ready, 0);
        chk("irq_ret_cmd", d2f_cmd, 0);
        cyc();
        chk("irq_valid", d2e_valid, 0);
        chk("irq_busy", dbg_pipeline_busy, 1);
        chk("irq_wait_ready", d2f_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", d2e_valid, 0);
        chk("arst_busy", dbg_pipeline_busy, 0);
        chk("arst_cmd", d2f_cmd, 0);
        chk("arst_ready", d2f_ready, 0);
        chk("arst_pc", d2e_pc, 0);
        cyc();
        rst = 1'b0;
        offer(0, 0, ADDI, 32'h0, 0);
        chk("post_rst_ready", d2f_ready, 1);
        chk("post_rst_cmd", d2f_cmd, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/armleocpu_decode.md
Name: armleocpu_decode

Overview:
- Second stage of the 3-stage pipeline, between fetch and execute.
- Accepts instruction packets from fetch on the F2D bus and holds them in a one-entry register that drives the D2E bus.
- Returns commands to fetch on the D2F bus: stall, branch and flush.
- Forwards redirect commands from execute and serializes system/fence.i instructions so nothing younger enters execute until they retire.

Parameters:
- RESET_VECTOR_UNUSED, 0, reserved; must be 0 (no functional effect).
- SERIALIZE_SYSTEM, 1, when 1, SYSTEM opcode and FENCE.I enter WAIT_SERIAL; when 0, only INTERRUPT_PENDING packets serialize.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- f2d_valid  in  1  fetch packet valid
- f2d_type  in  `F2E_TYPE_WIDTH  INSTR or INTERRUPT_PENDING
- f2d_instr  in  32  instruction word
- f2d_pc  in  32  instruction PC
- d2f_ready  out  1  packet accepted / d2f_cmd valid
- d2f_cmd  out  `ARMLEOCPU_D2F_CMD_WIDTH  NONE, START_BRANCH, FLUSH
- d2f_branchtarget  out  32  target for START_BRANCH
- d2e_valid  out  1  registered packet valid
- d2e_type  out  `F2E_TYPE_WIDTH  registered type
- d2e_instr  out  32  registered instruction
- d2e_pc  out  32  registered PC
- d2e_illegal  out  1  instr[1:0] != 2'b11 (registered)
- d2e_serialize  out  1  registered packet is serializing
- e2d_ready  in  1  execute consumes d2e packet this cycle
- e2d_cmd  in  `ARMLEOCPU_D2F_CMD_WIDTH  redirect from execute
- e2d_branchtarget  in  32  execute redirect target
- dbg_pipeline_busy  out  1  decode holds a packet or is in WAIT_SERIAL

Behaviour:
Reset:
- On rst, asynchronously: d2e_valid=0, state=RUN, serial_pc=0.
- All d2e data registers clear to 0.
- Outputs during reset: d2f_cmd=NONE, d2f_ready=0.
- Reset mid-operation discards the held packet and any serialization with no residual command.

States:
- RUN: normal flow.
- WAIT_SERIAL: a serializing packet has been accepted; new packets are blocked until release.

Priority 1, redirect (e2d_cmd != NONE, any state):
- Combinationally d2f_ready=1, d2f_cmd=e2d_cmd, d2f_branchtarget=e2d_branchtarget.
- The F2D packet offered that cycle is dropped.
- d2e_valid<=0 and state<=RUN next cycle.
- Execute issues at most one redirect per packet.

Priority 2, RUN with no redirect:
- can_accept = !d2e_valid || e2d_ready.
- d2f_ready = can_accept, d2f_cmd=NONE.
- If f2d_valid && can_accept: load the d2e registers, d2e_valid<=1, d2e_illegal<=(f2d_instr[1:0]!=2'b11).
- d2e_serialize<=1 when f2d_type==INTERRUPT_PENDING, or when SERIALIZE_SYSTEM and either:
  - opcode==7'b1110011, or
  - opcode==7'b0001111 with funct3==3'b001.
- When the loaded packet has serialize=1: state<=WAIT_SERIAL, serial_pc<=f2d_pc.
- Otherwise, if e2d_ready, d2e_valid<=0.
- Latency F2D to D2E is 1 cycle. Full throughput is one packet per cycle with back-to-back handshakes.

Priority 3, WAIT_SERIAL with no redirect:
- d2f_ready=0 while d2e_valid && !e2d_ready. Fetch holds its packet.
- On the retire cycle (d2e_valid && e2d_ready):
  - FENCE.I: d2f_ready=1, d2f_cmd=FLUSH.
  - INTERRUPT_PENDING: d2f_ready=0, d2f_cmd=NONE, stay in WAIT_SERIAL with d2e_valid<=0. Only a redirect releases it.
  - Otherwise: d2f_ready=1, d2f_cmd=START_BRANCH, target=serial_pc+4 (mod 2^32, wraps 0xFFFFFFFC to 0).
  - d2e_valid<=0. state<=RUN, except in the INTERRUPT_PENDING case above.
  - The F2D packet in the retire cycle is never captured. Fetch discards it because of the command.

Other rules:
- d2e_* outputs are stable while d2e_valid && !e2d_ready.
- dbg_pipeline_busy = d2e_valid || state==WAIT_SERIAL.

Test Plan:
1. Reset, then stream ADDI at pc 0x1000, 0x1004, 0x1008 with e2d_ready=1 → d2e_valid each following cycle with matching pc; d2f_ready=1 continuously; d2f_cmd=NONE.
2. Packet at 0x2000 held with e2d_ready=0 for 3 cycles while f2d_valid=1 → d2f_ready=0; d2e_pc stays 0x2000; the next packet loads on the cycle e2d_ready=1.
3. CSRRW (0x34011073) at pc 0x3000 accepted, then e2d_ready=1 → the following fetch packet is not loaded; on the retire cycle d2f_cmd=START_BRANCH, target 0x3004, d2f_ready=1; state returns to RUN.
4. FENCE.I (0x0000100F) at 0x4000 retires → d2f_cmd=FLUSH exactly one cycle; no packet captured that cycle.
5. e2d_cmd=START_BRANCH, target 0x8000, while d2e_valid=1 and f2d_valid=1 → d2f_cmd=START_BRANCH, d2f_branchtarget=0x8000 same cycle; d2e_valid=0 next cycle; offered packet dropped.
6. INTERRUPT_PENDING packet accepted, retired, then rst asserted mid-WAIT_SERIAL → state RUN, d2e_valid=0 immediately (asynchronous); d2f_cmd=NONE.
